// File: rtl/carfield_pkg.sv
// carfield_pkg: shared Carfield constants, power-state encoding and counter sizing helper
package carfield_pkg;
  localparam int unsigned NumDomains = 6;
  typedef enum logic [2:0] {OFF, CLK_ON, RST_OFF, ON, ISO_ON, RST_ON} carfield_pwr_state_e;
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b, input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/carfield_domain_pwr_fsm.sv
// carfield_domain_pwr_fsm: single-domain timed clock/reset/isolation sequencer with registered outputs
module carfield_domain_pwr_fsm
  import carfield_pkg::*;
#(
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned IsoCycles       = 4,
  parameter int unsigned RstCycles       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                grant_i,
  output logic                clk_en_o,
  output logic                rst_no,
  output logic                iso_o,
  output logic                pwr_on_o,
  output logic                busy_o,
  output carfield_pwr_state_e state_o
);
  localparam int unsigned CntW = cnt_width(ClkSettleCycles, IsoCycles, RstCycles);
  carfield_pwr_state_e state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic done;
  assign done = cnt_q == '0;
  always_comb begin
    state_d = state_o;
    cnt_d   = done ? cnt_q : cnt_q - 1'b1;
    case (state_o)
      OFF:     if (req_i && grant_i) begin
                 state_d = CLK_ON;
                 cnt_d   = CntW'(ClkSettleCycles - 1);
               end
      CLK_ON:  if (done) begin
                 state_d = RST_OFF;
                 cnt_d   = CntW'(IsoCycles - 1);
               end
      RST_OFF: if (done) state_d = ON;
      ON:      if (!req_i && grant_i) begin
                 state_d = ISO_ON;
                 cnt_d   = CntW'(IsoCycles - 1);
               end
      ISO_ON:  if (done) begin
                 state_d = RST_ON;
                 cnt_d   = CntW'(RstCycles - 1);
               end
      RST_ON:  if (done) state_d = OFF;
      default: state_d = OFF;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_o  <= OFF;
      cnt_q    <= '0;
      clk_en_o <= 1'b0;
      rst_no   <= 1'b0;
      iso_o    <= 1'b1;
      pwr_on_o <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_o  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_o <= state_d != OFF;
      rst_no   <= state_d inside {RST_OFF, ON, ISO_ON};
      iso_o    <= state_d != ON;
      pwr_on_o <= state_d == ON;
      busy_o   <= !(state_d inside {OFF, ON});
    end
  end
endmodule

// File: rtl/carfield_domain_pwr_seq.sv
// carfield_domain_pwr_seq: per-domain power sequencers with optional fixed-priority serialisation
module carfield_domain_pwr_seq #(
  parameter int unsigned                  NumDomains      = carfield_pkg::NumDomains,
  parameter int unsigned                  ClkSettleCycles = 4,
  parameter int unsigned                  IsoCycles       = 4,
  parameter int unsigned                  RstCycles       = 16,
  parameter bit                           Serialise       = 1'b1,
  parameter logic [NumDomains-1:0]        ForceOnMask     = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumDomains-1:0]   en_req_i,
  output logic [NumDomains-1:0]   clk_en_o,
  output logic [NumDomains-1:0]   rst_no,
  output logic [NumDomains-1:0]   iso_o,
  output logic [NumDomains-1:0]   pwr_on_o,
  output logic                    busy_o,
  output logic [3*NumDomains-1:0] state_o
);
  import carfield_pkg::*;
  logic [NumDomains-1:0] req, busy, mismatch, grant;
  carfield_pwr_state_e st [NumDomains];
  assign req    = en_req_i | ForceOnMask;
  assign busy_o = |busy;
  assign grant  = !Serialise ? '1 : busy_o ? '0 : mismatch & (~mismatch + 1'b1);
  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    assign mismatch[d]       = req[d] != (st[d] == ON);
    assign state_o[3*d +: 3] = st[d];
    carfield_domain_pwr_fsm #(
      .ClkSettleCycles(ClkSettleCycles),
      .IsoCycles      (IsoCycles),
      .RstCycles      (RstCycles)
    ) u_fsm (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (req[d]),
      .grant_i (grant[d]),
      .clk_en_o(clk_en_o[d]),
      .rst_no  (rst_no[d]),
      .iso_o   (iso_o[d]),
      .pwr_on_o(pwr_on_o[d]),
      .busy_o  (busy[d]),
      .state_o (st[d])
    );
  end
endmodule

// File: tb/tb_carfield_domain_pwr_seq.sv
// tb_carfield_domain_pwr_seq: three sequencer configurations checked every cycle against a timeline model
module tb_carfield_domain_pwr_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] en_req;
  logic [5:0] clk_en [3];
  logic [5:0] rstn_out [3];
  logic [5:0] iso [3];
  logic [5:0] pwr_on [3];
  logic busy [3];
  logic [17:0] st [3];
  int n_chk = 0;
  int n_fail = 0;
  int ser [3] = '{1, 0, 1};
  logic [5:0] mask [3] = '{6'b000000, 6'b000000, 6'b000001};
  string nm [3] = '{"ser", "par", "frc"};
  int stab [3][6];
  int tr [3][6];
  int dir [3][6];
  int el [3][6];
  always #5 clk = ~clk;
  carfield_domain_pwr_seq #(.Serialise(1'b1), .ForceOnMask(6'b000000)) u_ser (
    .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .clk_en_o(clk_en[0]), .rst_no(rstn_out[0]),
    .iso_o(iso[0]), .pwr_on_o(pwr_on[0]), .busy_o(busy[0]), .state_o(st[0]));
  carfield_domain_pwr_seq #(.Serialise(1'b0), .ForceOnMask(6'b000000)) u_par (
    .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .clk_en_o(clk_en[1]), .rst_no(rstn_out[1]),
    .iso_o(iso[1]), .pwr_on_o(pwr_on[1]), .busy_o(busy[1]), .state_o(st[1]));
  carfield_domain_pwr_seq #(.Serialise(1'b1), .ForceOnMask(6'b000001)) u_frc (
    .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .clk_en_o(clk_en[2]), .rst_no(rstn_out[2]),
    .iso_o(iso[2]), .pwr_on_o(pwr_on[2]), .busy_o(busy[2]), .state_o(st[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int d = 0; d < 6; d++) begin
        stab[i][d] = 0; tr[i][d] = 0; dir[i][d] = 0; el[i][d] = 0;
      end
  endtask
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int any_tr;
      int taken;
      any_tr = 0;
      taken = 0;
      for (int d = 0; d < 6; d++) any_tr |= tr[i][d];
      for (int d = 0; d < 6; d++) begin
        int req;
        req = (en_req[d] | mask[i][d]) ? 1 : 0;
        if (tr[i][d] != 0) begin
          el[i][d]++;
          if (el[i][d] == (dir[i][d] != 0 ? 8 : 20)) begin
            tr[i][d] = 0;
            stab[i][d] = dir[i][d];
          end
        end else if (req != stab[i][d] && (ser[i] == 0 || (any_tr == 0 && taken == 0))) begin
          tr[i][d] = 1; dir[i][d] = req; el[i][d] = 0; taken = 1;
        end
      end
    end
  endtask
  function automatic int exp_state(input int i, input int d);
    if (tr[i][d] == 0) return stab[i][d] != 0 ? 3 : 0;
    if (dir[i][d] != 0) return el[i][d] < 4 ? 1 : 2;
    return el[i][d] < 4 ? 4 : 5;
  endfunction
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      logic [5:0] e_clk, e_rst, e_iso, e_pwr;
      logic [17:0] e_st;
      logic e_busy;
      int n_tr;
      e_busy = 1'b0;
      n_tr = 0;
      for (int d = 0; d < 6; d++) begin
        e_clk[d] = (tr[i][d] | stab[i][d]) != 0;
        e_rst[d] = tr[i][d] != 0 ? (dir[i][d] != 0 ? el[i][d] >= 4 : el[i][d] < 4) : stab[i][d] != 0;
        e_pwr[d] = tr[i][d] == 0 && stab[i][d] != 0;
        e_iso[d] = !e_pwr[d];
        e_st[3*d +: 3] = 3'(exp_state(i, d));
        e_busy |= tr[i][d] != 0;
        if (!(st[i][3*d +: 3] inside {3'd0, 3'd3})) n_tr++;
      end
      chk($sformatf("%s.clk_en", nm[i]), 32'(clk_en[i]), 32'(e_clk));
      chk($sformatf("%s.rst_n", nm[i]), 32'(rstn_out[i]), 32'(e_rst));
      chk($sformatf("%s.iso", nm[i]), 32'(iso[i]), 32'(e_iso));
      chk($sformatf("%s.pwr_on", nm[i]), 32'(pwr_on[i]), 32'(e_pwr));
      chk($sformatf("%s.busy", nm[i]), 32'(busy[i]), 32'(e_busy));
      chk($sformatf("%s.state", nm[i]), 32'(st[i]), 32'(e_st));
      if (ser[i] != 0) chk($sformatf("%s.one_transient", nm[i]), 32'(n_tr <= 1), 32'd1);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    rst_n = 1'b0;
    en_req = '0;
    model_reset();
    @(negedge clk);
    chk("rst.clk_en", 32'(clk_en[0]), 32'h00);
    chk("rst.rst_n", 32'(rstn_out[0]), 32'h00);
    chk("rst.iso", 32'(iso[0]), 32'h3f);
    chk("rst.busy", 32'(busy[0]), 32'h0);
    chk("rst.state", 32'(st[0]), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("idle.clk_en", 32'(clk_en[0]), 32'h00);
    chk("idle.iso", 32'(iso[0]), 32'h3f);
    for (int k = 0; k < 30; k++) cycle();
    chk("force.pwr_on0", 32'(pwr_on[2][0]), 32'h1);
    en_req = 6'b000100;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      if (k == 1) chk("up.clk_en_k1", 32'(clk_en[1][2]), 32'h1);
      if (k == 4) chk("up.rst_n_k4", 32'(rstn_out[1][2]), 32'h0);
      if (k == 5) chk("up.rst_n_k5", 32'(rstn_out[1][2]), 32'h1);
      if (k == 8) chk("up.pwr_on_k8", 32'(pwr_on[1][2]), 32'h0);
      if (k == 9) chk("up.pwr_on_k9", 32'(pwr_on[1][2]), 32'h1);
      if (k == 9) chk("up.iso_k9", 32'(iso[1][2]), 32'h0);
    end
    for (int k = 0; k < 12; k++) cycle();
    en_req = 6'b000000;
    for (int k = 1; k <= 21; k++) begin
      cycle();
      if (k == 1) chk("dn.iso_k1", 32'(iso[1][2]), 32'h1);
      if (k == 4) chk("dn.rst_n_k4", 32'(rstn_out[1][2]), 32'h1);
      if (k == 5) chk("dn.rst_n_k5", 32'(rstn_out[1][2]), 32'h0);
      if (k == 20) chk("dn.clk_en_k20", 32'(clk_en[1][2]), 32'h1);
      if (k <= 20) chk("dn.busy", 32'(busy[1]), 32'h1);
      if (k == 21) chk("dn.clk_en_k21", 32'(clk_en[1][2]), 32'h0);
      if (k == 21) chk("dn.busy_k21", 32'(busy[1]), 32'h0);
    end
    for (int k = 0; k < 25; k++) cycle();
    en_req = 6'b000101;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (k == 9) chk("ser.d0_on", 32'(st[0][2:0]), 32'd3);
      if (k == 9) chk("ser.d2_wait", 32'(st[0][8:6]), 32'd0);
      if (k == 10) chk("ser.d2_start", 32'(st[0][8:6]), 32'd1);
      if (k == 18) chk("ser.d2_on", 32'(st[0][8:6]), 32'd3);
    end
    en_req = 6'b000000;
    for (int k = 0; k < 60; k++) cycle();
    en_req = 6'b000010;
    cycle();
    en_req = 6'b000000;
    for (int k = 2; k <= 32; k++) begin
      cycle();
      if (k == 9) chk("pulse.pwr_on", 32'(pwr_on[1][1]), 32'h1);
      if (k == 10) chk("pulse.iso_on", 32'(st[1][5:3]), 32'd4);
      if (k == 29) chk("pulse.rst_on", 32'(st[1][5:3]), 32'd5);
      if (k == 30) chk("pulse.off", 32'(st[1][5:3]), 32'd0);
    end
    en_req = 6'b001000;
    cycle();
    cycle();
    chk("arst.pre_clk_on", 32'(st[1][11:9]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.clk_en", 32'(clk_en[1]), 32'h00);
    chk("arst.rst_n", 32'(rstn_out[1]), 32'h00);
    chk("arst.iso", 32'(iso[1]), 32'h3f);
    chk("arst.state", 32'(st[1]), 32'h0);
    chk("arst.busy", 32'(busy[1]), 32'h0);
    model_reset();
    en_req = 6'b000000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, 5);
        en_req[b] = ~en_req[b];
      end
      cycle();
    end
    chk("force.still_on", 32'(pwr_on[2][0]), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
